// File: rtl/ans_ht_stf_sink_if.sv
// Output sample stream of the HT-STF sink: 32-bit {I,Q} words with a burst-last marker.
interface ans_ht_stf_sink_if;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tlast;

  modport master (output o_tdata, output o_tvalid, output o_tlast, input o_tready);
  modport slave  (input o_tdata, input o_tvalid, input o_tlast, output o_tready);
endinterface

// File: rtl/ans_ht_stf_sink.sv
// Sequences the HT-STF generator, captures its burst through gain/window into a FIFO, replays it on tx.
// Accept-to-o_tvalid >= 2 cycles; output stalls hold data; capture never stalls. Window: ANS_HT_STF_SINK_WINDOW_EN.
module ans_ht_stf_sink #(
  parameter int N_SAMPLES  = 80,
  parameter int FIFO_LG    = 7,
  parameter int GAIN_SHIFT = 0,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           stf_sample,
  input  logic                  stf_started,
  output logic                  letsgo,
  output logic                  givemeoutput,
  ans_ht_stf_sink_if.master     tx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int DEPTH = 1 << FIFO_LG;
  localparam int PTR_W = FIFO_LG + 1;
  localparam int IDX_W = $clog2(N_SAMPLES + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_KICK, S_WAIT_START, S_CAPTURE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   tmo_cnt;

  logic               accept;
  logic [IDX_W-1:0]   cur_idx;
  logic               is_last;
  logic [15:0]        i_y;
  logic [15:0]        q_y;

  logic               wr_vld;
  logic               wr_last;
  logic [31:0]        wr_dat;

  logic [32:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   count;
  logic [PTR_W-1:0]   free_cnt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               out_vld;
  logic               out_last;
  logic [31:0]        out_dat;
  logic               out_free;
  logic               bypass;
  logic               do_read;
  logic               do_write;
  logic               wr_drop;

  function automatic logic [15:0] gain_sat(input logic [15:0] x);
    logic signed [19:0] wide;
    wide = {{4{x[15]}}, x} << GAIN_SHIFT;
    if (wide > 20'sd32767)
      return 16'h7fff;
    else if (wide < -20'sd32768)
      return 16'h8000;
    else
      return wide[15:0];
  endfunction

  assign accept  = ((state == S_WAIT_START) && stf_started) || (state == S_CAPTURE);
  assign cur_idx = (state == S_CAPTURE) ? idx : '0;
  assign is_last = (cur_idx == IDX_W'(N_SAMPLES - 1));

`ifdef ANS_HT_STF_SINK_WINDOW_EN
  logic edge_s;
  assign edge_s = (cur_idx == '0) || is_last;

  always_comb begin
    i_y = gain_sat(stf_sample[31:16]);
    q_y = gain_sat(stf_sample[15:0]);
    // Arithmetic halving rounds toward -inf, matching the reference preamble.
    if (edge_s) begin
      i_y = {i_y[15], i_y[15:1]};
      q_y = {q_y[15], q_y[15:1]};
    end
  end
`else
  always_comb begin
    i_y = gain_sat(stf_sample[31:16]);
    q_y = gain_sat(stf_sample[15:0]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld  <= 1'b0;
      wr_last <= 1'b0;
      wr_dat  <= '0;
    end else begin
      wr_vld  <= accept;
      wr_last <= accept && is_last;
      if (accept)
        wr_dat <= {i_y, q_y};
    end
  end

  assign count      = wr_ptr - rd_ptr;
  assign free_cnt   = PTR_W'(DEPTH) - count;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == PTR_W'(DEPTH));
  assign out_free   = !out_vld || tx.o_tready;
  // An empty FIFO lets the write stage load the output register directly.
  assign bypass     = wr_vld && fifo_empty && out_free;
  assign do_read    = out_free && !fifo_empty;
  assign do_write   = wr_vld && !bypass && !fifo_full;
  assign wr_drop    = wr_vld && !bypass && fifo_full;

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr[FIFO_LG-1:0]] <= {wr_last, wr_dat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_read) begin
        {out_last, out_dat} <= mem[rd_ptr[FIFO_LG-1:0]];
        out_vld             <= 1'b1;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end else if (bypass) begin
        out_last <= wr_last;
        out_dat  <= wr_dat;
        out_vld  <= 1'b1;
      end else if (out_free) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign tx.o_tdata  = out_dat;
  assign tx.o_tvalid = out_vld;
  assign tx.o_tlast  = out_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      letsgo       <= 1'b0;
      givemeoutput <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tmo_cnt      <= '0;
      idx          <= '0;
    end else begin
      letsgo <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= S_ARM;
          end
        end
        S_ARM: begin
          if (free_cnt >= PTR_W'(N_SAMPLES)) begin
            letsgo <= 1'b1;
            state  <= S_KICK;
          end
        end
        S_KICK: begin
          givemeoutput <= 1'b1;
          tmo_cnt      <= '0;
          state        <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (stf_started) begin
            if (is_last) begin
              givemeoutput <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= S_IDLE;
            end else begin
              idx   <= IDX_W'(1);
              state <= S_CAPTURE;
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            err          <= 1'b1;
            givemeoutput <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          // stf_started drops mid-burst during the generator's recycle phase.
          if (is_last) begin
            givemeoutput <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= S_IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (wr_drop)
        err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ans_ht_stf_sink.sv
// Bench for ans_ht_stf_sink: two instances (gain 0 and gain 2) fed the same generator stimulus.
module tb_ans_ht_stf_sink;
  localparam int N   = 80;
  localparam int TMO = 1023;
`ifdef ANS_HT_STF_SINK_WINDOW_EN
  localparam bit WIN = 1'b1;
`else
  localparam bit WIN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stf_started = 1'b0;
  logic [31:0] stf_sample = '0;
  logic        ready = 1'b1;
  logic        throttle = 1'b0;
  int          cyc = 0;

  logic letsgo0, gmo0, busy0, done0, err0;
  logic letsgo2, gmo2, busy2, done2, err2;

  ans_ht_stf_sink_if if0 ();
  ans_ht_stf_sink_if if2 ();
  assign if0.o_tready = ready;
  assign if2.o_tready = ready;

  ans_ht_stf_sink #(.GAIN_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stf_sample(stf_sample), .stf_started(stf_started),
    .letsgo(letsgo0), .givemeoutput(gmo0), .tx(if0.master), .busy(busy0), .done(done0), .err(err0));
  ans_ht_stf_sink #(.GAIN_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stf_sample(stf_sample), .stf_started(stf_started),
    .letsgo(letsgo2), .givemeoutput(gmo2), .tx(if2.master), .busy(busy2), .done(done2), .err(err2));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = i[15:0];
    b = q[15:0];
    return {a, b};
  endfunction

  function automatic logic [15:0] ref_comp(input logic [15:0] x, input int gs, input bit edge_s);
    int v;
    v = int'($signed(x)) * (1 << gs);
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    if (WIN && edge_s) v = v >>> 1;
    return v[15:0];
  endfunction

  typedef struct {
    logic [31:0] in;
    logic [31:0] g0_mid;
    logic [31:0] g0_edge;
    logic [31:0] g2_mid;
    logic [31:0] g2_edge;
  } vec_t;
  vec_t vecs [6];

  logic [32:0] exp0 [$];
  logic [32:0] exp2 [$];

  // Scoreboard side: every transfer pops one expected word; stalled words must hold.
  logic        hold0 = 1'b0, hold2 = 1'b0;
  logic [32:0] last0, last2, e0m, e2m;
  always @(negedge clk) begin
    if (reset) begin
      hold0 = 1'b0;
      hold2 = 1'b0;
    end else begin
      if (hold0) cmp("hold_g0", {if0.o_tvalid, if0.o_tlast, if0.o_tdata}, {1'b1, last0});
      if (hold2) cmp("hold_g2", {if2.o_tvalid, if2.o_tlast, if2.o_tdata}, {1'b1, last2});
      if (if0.o_tvalid && ready) begin
        e0m = (exp0.size() != 0) ? exp0.pop_front() : 33'bx;
        cmp("out_g0", {if0.o_tlast, if0.o_tdata}, e0m);
      end
      if (if2.o_tvalid && ready) begin
        e2m = (exp2.size() != 0) ? exp2.pop_front() : 33'bx;
        cmp("out_g2", {if2.o_tlast, if2.o_tdata}, e2m);
      end
      hold0 = if0.o_tvalid && !ready;
      hold2 = if2.o_tvalid && !ready;
      last0 = {if0.o_tlast, if0.o_tdata};
      last2 = {if2.o_tlast, if2.o_tdata};
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    ready = throttle ? (cyc % 3 == 0) : 1'b1;
  end

  // mode 0: ramp {k,-k}; mode 1: constant table vector vi; mode 2: random words.
  task automatic run_burst(input int mode, input int vi, input int rst_at, input bit chk_arm);
    int n;
    logic [31:0] s, x0, x2;
    bit e, l;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cmp("start_state", {err0, err2, busy0, busy2}, 4'b0011);
    n = 0;
    while (!letsgo0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    cmp("letsgo_seen", {letsgo0, letsgo2}, 2'b11);
    if (chk_arm) begin
      cmp("arm_waited", (n >= 3), 1);
      cmp("arm_free", (exp0.size() <= 49), 1);
    end
    @(negedge clk);
    cmp("letsgo_pulse", {letsgo0, letsgo2, gmo0, gmo2}, 4'b0011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        stf_started = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cmp("reset_mid", {letsgo0, gmo0, if0.o_tvalid, if0.o_tlast, busy0, done0, err0,
                          letsgo2, gmo2, if2.o_tvalid, if2.o_tlast, busy2, done2, err2}, 14'h0);
        exp0.delete();
        exp2.delete();
        reset = 1'b0;
        n = 0;
        repeat (6) begin
          @(negedge clk);
          n += int'(if0.o_tvalid) + int'(if2.o_tvalid);
        end
        cmp("flushed_empty", n, 0);
        return;
      end
      case (mode)
        0: s = pk(k, -k);
        1: s = vecs[vi].in;
        default: s = $urandom;
      endcase
      e = (k == 0) || (k == N - 1);
      l = (k == N - 1);
      if (mode == 1) begin
        x0 = (WIN && e) ? vecs[vi].g0_edge : vecs[vi].g0_mid;
        x2 = (WIN && e) ? vecs[vi].g2_edge : vecs[vi].g2_mid;
      end else begin
        x0 = {ref_comp(s[31:16], 0, e), ref_comp(s[15:0], 0, e)};
        x2 = {ref_comp(s[31:16], 2, e), ref_comp(s[15:0], 2, e)};
      end
      exp0.push_back({l, x0});
      exp2.push_back({l, x2});
      stf_sample  = s;
      stf_started = (k < 64);
      @(negedge clk);
      cmp("done_early", {done0, done2}, 2'b00);
      @(posedge clk); #1;
    end
    stf_started = 1'b0;
    stf_sample  = '0;
    @(negedge clk);
    cmp("done_pulse", {done0, done2, busy0, busy2, gmo0, gmo2}, 6'b110000);
    @(negedge clk);
    cmp("done_clear", {done0, done2}, 2'b00);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp2.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmp("drain_left", exp0.size() + exp2.size(), 0);
  endtask

  task automatic timeout_test();
    int n;
    int vld_seen;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!letsgo0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmp("tmo_letsgo", letsgo0, 1);
    n = 0;
    vld_seen = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) cmp("tmo_gmo", {gmo0, gmo2}, 2'b11);
      vld_seen += int'(if0.o_tvalid) + int'(if2.o_tvalid);
    end while (!err0 && n < TMO + 20);
    // err is registered on the TIMEOUT-th edge after the KICK cycle.
    cmp("tmo_cycles", n, TMO + 1);
    cmp("tmo_state", {err0, err2, busy0, busy2, gmo0, gmo2}, 6'b110000);
    cmp("tmo_no_output", vld_seen, 0);
  endtask

  initial begin
    vecs[0] = '{pk(1000, -1000), pk(1000, -1000), pk(500, -500), pk(4000, -4000), pk(2000, -2000)};
    vecs[1] = '{pk(-3, 3), pk(-3, 3), pk(-2, 1), pk(-12, 12), pk(-6, 6)};
    vecs[2] = '{pk(12000, -9000), pk(12000, -9000), pk(6000, -4500), pk(32767, -32768), pk(16383, -16384)};
    vecs[3] = '{pk(100, -100), pk(100, -100), pk(50, -50), pk(400, -400), pk(200, -200)};
    vecs[4] = '{pk(32767, -32768), pk(32767, -32768), pk(16383, -16384), pk(32767, -32768), pk(16383, -16384)};
    vecs[5] = '{pk(-1, 1), pk(-1, 1), pk(-1, 0), pk(-4, 4), pk(-2, 2)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_state", {letsgo0, gmo0, if0.o_tvalid, if0.o_tlast, busy0, done0, err0,
                        letsgo2, gmo2, if2.o_tvalid, if2.o_tlast, busy2, done2, err2}, 14'h0);
    reset = 1'b0;

    run_burst(0, 0, -1, 1'b0);
    drain();

    for (int v = 0; v < 6; v++) begin
      run_burst(1, v, -1, 1'b0);
      drain();
    end

    timeout_test();
    run_burst(0, 0, -1, 1'b0);
    drain();

    throttle = 1'b1;
    run_burst(2, 0, -1, 1'b0);
    run_burst(2, 0, -1, 1'b1);
    throttle = 1'b0;
    drain();

    run_burst(0, 0, 40, 1'b0);
    run_burst(0, 0, -1, 1'b0);
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
